hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage core; sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and EX/MEM write/bubble controls.
- Resolves load-use hazards, taken-branch flushes, and multi-cycle MUL/DIV occupancy of EX, which uses an internal FSM and countdown.
- Keeps a saturating count of front-end stall cycles for performance monitoring.

---
 rtl/hazard_stall_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use, taken-branch flush and MUL/DIV
// occupancy of EX, plus a saturating front-end stall counter.
module hazard_stall_ctrl #(
    parameter int REG_WIDTH  = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_WIDTH-1:0] ifid_rs1,
    input  logic [REG_WIDTH-1:0] ifid_rs2,
    input  logic [REG_WIDTH-1:0] idex_rd,
    input  logic                 idex_memread,
    input  logic                 idex_md_op,
    input  logic                 branch_taken,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_write,
    output logic                 idex_bubble,
    output logic                 exmem_bubble,
    output logic                 md_start,
    output logic                 md_busy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    if (MD_LATENCY < 2 || MD_LATENCY > 16) begin : g_bad_latency
        $error("hazard_stall_ctrl: MD_LATENCY must be within 2..16");
    end

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    // Countdown starts at LATENCY-2: the start cycle and the release
    // cycle are both outside the MD_BUSY stall window.
    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] md_cnt;
    logic [3:0] md_cnt_nxt;
    logic       load_use;

    assign load_use = idex_memread
                   && (idex_rd != '0)
                   && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (idex_md_op) begin
                        md_start     = 1'b1;
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        md_cnt_nxt   = MD_INIT;
                        state_nxt    = MD_BUSY;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (md_cnt != 4'd0) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        md_cnt_nxt   = md_cnt - 4'd1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            md_cnt    <= 4'd0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (latency 4 / 16-bit count,
// latency 2 / 4-bit count) checked against a cycle-phase model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       idex_memread, idex_md_op, branch_taken;

    logic pw_a, iw_a, fl_a, xw_a, xb_a, eb_a, ms_a, mb_a;
    logic pw_b, iw_b, fl_b, xw_b, xb_b, eb_b, ms_b, mb_b;
    logic [15:0] c_a;
    logic [3:0]  c_b;
    logic [7:0]  o_a, o_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_WIDTH(5), .MD_LATENCY(4), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .idex_md_op(idex_md_op),
        .branch_taken(branch_taken),
        .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(fl_a),
        .idex_write(xw_a), .idex_bubble(xb_a), .exmem_bubble(eb_a),
        .md_start(ms_a), .md_busy(mb_a), .stall_cnt(c_a)
    );

    hazard_stall_ctrl #(.REG_WIDTH(5), .MD_LATENCY(2), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .idex_md_op(idex_md_op),
        .branch_taken(branch_taken),
        .pc_write(pw_b), .ifid_write(iw_b), .ifid_flush(fl_b),
        .idex_write(xw_b), .idex_bubble(xb_b), .exmem_bubble(eb_b),
        .md_start(ms_b), .md_busy(mb_b), .stall_cnt(c_b)
    );

    // Bit order: pc_write, ifid_write, ifid_flush, idex_write,
    // idex_bubble, exmem_bubble, md_start, md_busy
    assign o_a = {pw_a, iw_a, fl_a, xw_a, xb_a, eb_a, ms_a, mb_a};
    assign o_b = {pw_b, iw_b, fl_b, xw_b, xb_b, eb_b, ms_b, mb_b};

    localparam logic [7:0] IDLE    = 8'hD0;
    localparam logic [7:0] LU      = 8'h18;
    localparam logic [7:0] BR      = 8'hF8;
    localparam logic [7:0] MDSTART = 8'h06;
    localparam logic [7:0] MDSTALL = 8'h05;
    localparam logic [7:0] MDREL   = 8'hD1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph = cycles elapsed since the MD op started (0 = no op).
    int ph[2] = '{0, 0};
    int mc[2] = '{0, 0};

    function automatic logic [7:0] model_out(input int lat, input int p);
        logic lu;
        lu = idex_memread && idex_rd != 0
          && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
        if (reset) return IDLE;
        if (p > 0) return (p < lat - 1) ? MDSTALL : MDREL;
        if (branch_taken) return BR;
        if (idex_md_op) return MDSTART;
        if (lu) return LU;
        return IDLE;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e;
            int lat, mx;
            lat = (i == 0) ? 4 : 2;
            mx  = (i == 0) ? 65535 : 15;
            e = model_out(lat, ph[i]);
            if (reset) begin
                ph[i] = 0;
                mc[i] = 0;
            end else begin
                if (!e[7]) mc[i] = (mc[i] < mx) ? mc[i] + 1 : mx;
                if (ph[i] > 0) ph[i] = (ph[i] >= lat - 1) ? 0 : ph[i] + 1;
                else if (!branch_taken && idex_md_op) ph[i] = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("out_a", int'(o_a), int'(model_out(4, ph[0])));
        check("cnt_a", int'(c_a), mc[0]);
        check("out_b", int'(o_b), int'(model_out(2, ph[1])));
        check("cnt_b", int'(c_b), mc[1]);
    end

    logic [7:0]  so_a, so_b;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;
    int st_a, st_b, sl_a, sl_b;

    task automatic run(input logic rst, input logic md, input logic mr,
                       input logic br, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
        reset        = rst;
        idex_md_op   = md;
        idex_memread = mr;
        branch_taken = br;
        idex_rd      = rd;
        ifid_rs1     = r1;
        ifid_rs2     = r2;
        @(negedge clk);
        #1;
        so_a = o_a; so_b = o_b; sc_a = c_a; sc_b = c_b;
        st_a += int'(ms_a); st_b += int'(ms_b);
        sl_a += int'(!pw_a); sl_b += int'(!pw_b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        run(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
    endtask

    task automatic clr();
        st_a = 0; st_b = 0; sl_a = 0; sl_b = 0;
    endtask

    initial begin
        logic md, mr, br, rst;
        clr();
        run(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd1, 5'd1);
        check("reset_idle", int'(so_a), int'(IDLE));
        check("reset_cnt", int'(sc_a), 0);
        idle_cyc();
        check("idle_after_reset", int'(so_a), int'(IDLE));

        run(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd9, 5'd5);
        check("loaduse_out", int'(so_a), int'(LU));
        idle_cyc();
        check("loaduse_cnt", int'(sc_a), 1);

        run(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7);
        check("x0_no_stall", int'(so_a), int'(IDLE));
        run(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd8);
        check("branch_wins", int'(so_a), int'(BR));
        idle_cyc();
        check("branch_cnt", int'(sc_a), 1);

        clr();
        for (int k = 0; k < 8; k++) begin
            run(1'b0, k < 4, 1'b0, 1'b0, 5'd4, 5'd4, 5'd4);
            if (k == 3) check("md_release", int'(so_a), int'(MDREL));
        end
        check("md_starts_a", st_a, 1);
        check("md_stalls_a", sl_a, 3);
        check("md_starts_b", st_b, 2);
        check("md_stalls_b", sl_b, 2);
        check("md_cnt_a", int'(sc_a), 4);
        check("md_cnt_b", int'(sc_b), 3);

        clr();
        for (int k = 0; k < 10; k++)
            run(1'b0, k < 8, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("b2b_starts_a", st_a, 2);
        check("b2b_stalls_a", sl_a, 6);
        check("b2b_starts_b", st_b, 4);
        check("b2b_cnt_a", int'(sc_a), 10);

        run(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("mid_busy", int'(so_a), int'(MDSTALL));
        run(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("rst_forced_idle", int'(so_a), int'(IDLE));
        idle_cyc();
        check("post_rst_idle", int'(so_a), int'(IDLE));
        check("post_rst_cnt", int'(sc_a), 0);
        idle_cyc();
        check("post_rst_quiet", int'(so_a), int'(IDLE));

        for (int k = 0; k < 20; k++)
            run(1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 5'd6, 5'd0);
        idle_cyc();
        check("sat_cnt_b", int'(sc_b), 15);
        check("sat_cnt_a", int'(sc_a), 20);

        for (int k = 0; k < 3000; k++) begin
            md  = ($urandom_range(0, 5) == 0);
            br  = !md && ($urandom_range(0, 5) == 0);
            mr  = !md && ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            run(rst, md, mr, br, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
